// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage feeding the ALU.
// Forwards MEM/WB results onto rs/rt, picks immediate or register for B,
// maps aluop/funct to the ALU function code and holds results in a
// two-entry skid buffer with valid/ready handshakes on both sides.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_aluop,
  input  logic [5:0]    in_funct,
  input  logic [4:0]    in_shamt,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  input  logic [DW-1:0] in_imm,
  input  logic          in_alusrc,
  input  logic [RW-1:0] in_dst,
  input  logic          fwd_mem_we,
  input  logic [RW-1:0] fwd_mem_reg,
  input  logic [DW-1:0] fwd_mem_val,
  input  logic          fwd_wb_we,
  input  logic [RW-1:0] fwd_wb_reg,
  input  logic [DW-1:0] fwd_wb_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [3:0]    out_f,
  output logic [4:0]    out_shamt,
  output logic [RW-1:0] out_dst,
  output logic          out_illegal
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
    logic [4:0]    shamt;
    logic [RW-1:0] dst;
    logic          illegal;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t        state, state_nx;
  beat_t         main_q, skid_q, new_beat;
  logic          in_ready_q;
  logic          accept, consume;
  logic          ld_main, ld_skid, mv_skid;
  logic [DW-1:0] fwd_rs, fwd_rt;
  logic [3:0]    dec_f;
  logic          dec_illegal;

  assign out_valid = (state != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  // Operand bypass: register 0 is never forwarded, MEM wins over WB
  always_comb begin
    fwd_rs = in_rs_val;
    if (in_rs != '0 && fwd_mem_we && fwd_mem_reg == in_rs)
      fwd_rs = fwd_mem_val;
    else if (in_rs != '0 && fwd_wb_we && fwd_wb_reg == in_rs)
      fwd_rs = fwd_wb_val;

    fwd_rt = in_rt_val;
    if (in_rt != '0 && fwd_mem_we && fwd_mem_reg == in_rt)
      fwd_rt = fwd_mem_val;
    else if (in_rt != '0 && fwd_wb_we && fwd_wb_reg == in_rt)
      fwd_rt = fwd_wb_val;
  end

  // aluop/funct to ALU function code; unknown funct flags illegal
  always_comb begin
    dec_f       = 4'b0010;
    dec_illegal = 1'b0;
    case (in_aluop)
      2'b00: dec_f = 4'b0010;
      2'b01: dec_f = 4'b0110;
      2'b11: dec_f = 4'b0001;
      default: begin
        case (in_funct)
          6'b100000: dec_f = 4'b0010;
          6'b100010: dec_f = 4'b0110;
          6'b100100: dec_f = 4'b0000;
          6'b100101: dec_f = 4'b0001;
          6'b101010: dec_f = 4'b0111;
          6'b000000: dec_f = 4'b0011;
          6'b000010: dec_f = 4'b1110;
          default: begin
            dec_f       = 4'b1111;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Assemble the beat captured on accept
  always_comb begin
    new_beat.a       = fwd_rs;
    new_beat.b       = in_alusrc ? in_imm : fwd_rt;
    new_beat.f       = dec_f;
    new_beat.shamt   = in_shamt;
    new_beat.dst     = in_dst;
    new_beat.illegal = dec_illegal;
  end

  // Skid-buffer next state and entry load controls; flush overrides all
  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          ld_main  = 1'b1;
          state_nx = ONE;
        end
      end
      ONE: begin
        if (consume && accept) begin
          ld_main = 1'b1;
        end else if (consume) begin
          state_nx = EMPTY;
        end else if (accept) begin
          ld_skid  = 1'b1;
          state_nx = TWO;
        end
      end
      TWO: begin
        if (consume) begin
          mv_skid  = 1'b1;
          state_nx = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      ld_main  = 1'b0;
      ld_skid  = 1'b0;
      mv_skid  = 1'b0;
    end
  end

  // State and registered ready; ready is precomputed from next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != TWO);
    end
  end

  // Entry payload registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main)
        main_q <= new_beat;
      else if (mv_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= new_beat;
    end
  end

  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_f       = main_q.f;
  assign out_shamt   = main_q.shamt;
  assign out_dst     = main_q.dst;
  assign out_illegal = main_q.illegal & out_valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode/forward vector table,
// directed backpressure/flush/reset sequences and randomized traffic
// checked against a queue-based reference model.
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [5:0] FN [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
  localparam logic [3:0] FC [7] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h3, 4'he};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_aluop;
  logic [5:0]    in_funct;
  logic [4:0]    in_shamt;
  logic [RW-1:0] in_rs, in_rt, in_dst;
  logic [DW-1:0] in_rs_val, in_rt_val, in_imm;
  logic          in_alusrc;
  logic          fwd_mem_we, fwd_wb_we;
  logic [RW-1:0] fwd_mem_reg, fwd_wb_reg;
  logic [DW-1:0] fwd_mem_val, fwd_wb_val;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a, out_b;
  logic [3:0]    out_f;
  logic [4:0]    out_shamt;
  logic [RW-1:0] out_dst;
  logic          out_illegal;

  alu_issue_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_alusrc(in_alusrc), .in_dst(in_dst),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_reg(fwd_mem_reg), .fwd_mem_val(fwd_mem_val),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_reg(fwd_wb_reg), .fwd_wb_val(fwd_wb_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_f(out_f), .out_shamt(out_shamt),
    .out_dst(out_dst), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid, ready, flush;
    logic [1:0]    aluop;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [RW-1:0] rs, rt, dst;
    logic [DW-1:0] rs_val, rt_val, imm;
    logic          alusrc;
    logic          mem_we;
    logic [RW-1:0] mem_reg;
    logic [DW-1:0] mem_val;
    logic          wb_we;
    logic [RW-1:0] wb_reg;
    logic [DW-1:0] wb_val;
  } stim_t;

  typedef struct {
    logic [DW-1:0] a, b;
    logic [3:0]    f;
    logic [4:0]    shamt;
    logic [RW-1:0] dst;
    logic          ill;
  } beat_t;

  typedef struct {
    stim_t s;
    beat_t e;
  } vec_t;

  beat_t         model_q[$];
  logic [DW-1:0] log_a[$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_src(input stim_t s, input logic [RW-1:0] r,
                                            input logic [DW-1:0] rf);
    if (r == 0) return rf;
    if (s.mem_we && s.mem_reg == r) return s.mem_val;
    if (s.wb_we && s.wb_reg == r) return s.wb_val;
    return rf;
  endfunction

  function automatic beat_t ref_beat(input stim_t s);
    beat_t b;
    b.a     = ref_src(s, s.rs, s.rs_val);
    b.b     = s.alusrc ? s.imm : ref_src(s, s.rt, s.rt_val);
    b.shamt = s.shamt;
    b.dst   = s.dst;
    b.ill   = 1'b0;
    if (s.aluop == 2'b00) b.f = 4'h2;
    else if (s.aluop == 2'b01) b.f = 4'h6;
    else if (s.aluop == 2'b11) b.f = 4'h1;
    else begin
      b.f   = 4'hf;
      b.ill = 1'b1;
      for (int unsigned i = 0; i < 7; i++)
        if (s.funct == FN[i]) begin
          b.f   = FC[i];
          b.ill = 1'b0;
        end
    end
    return b;
  endfunction

  function automatic stim_t idle(input logic rdy);
    stim_t s;
    s = '{default: '0};
    s.ready = rdy;
    return s;
  endfunction

  function automatic stim_t simple(input logic [DW-1:0] k, input logic rdy);
    stim_t s;
    s = idle(rdy);
    s.valid  = 1'b1;
    s.rs_val = k;
    s.rt_val = k + 1;
    s.dst    = k[RW-1:0];
    return s;
  endfunction

  function automatic vec_t mkv(
    input logic [1:0] aluop, input logic [5:0] funct, input logic [4:0] shamt,
    input logic [RW-1:0] rs, input logic [DW-1:0] rs_val,
    input logic [RW-1:0] rt, input logic [DW-1:0] rt_val,
    input logic alusrc, input logic [DW-1:0] imm,
    input logic mem_we, input logic [RW-1:0] mem_reg, input logic [DW-1:0] mem_val,
    input logic wb_we, input logic [RW-1:0] wb_reg, input logic [DW-1:0] wb_val,
    input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic [3:0] ef, input logic eill);
    vec_t v;
    v.s = idle(1'b1);
    v.s.valid = 1'b1;
    v.s.aluop = aluop; v.s.funct = funct; v.s.shamt = shamt;
    v.s.rs = rs; v.s.rs_val = rs_val; v.s.rt = rt; v.s.rt_val = rt_val;
    v.s.alusrc = alusrc; v.s.imm = imm;
    v.s.mem_we = mem_we; v.s.mem_reg = mem_reg; v.s.mem_val = mem_val;
    v.s.wb_we = wb_we; v.s.wb_reg = wb_reg; v.s.wb_val = wb_val;
    v.e.a = ea; v.e.b = eb; v.e.f = ef; v.e.shamt = shamt; v.e.dst = '0; v.e.ill = eill;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    in_valid = s.valid; out_ready = s.ready; flush = s.flush;
    in_aluop = s.aluop; in_funct = s.funct; in_shamt = s.shamt;
    in_rs = s.rs; in_rt = s.rt; in_dst = s.dst;
    in_rs_val = s.rs_val; in_rt_val = s.rt_val; in_imm = s.imm; in_alusrc = s.alusrc;
    fwd_mem_we = s.mem_we; fwd_mem_reg = s.mem_reg; fwd_mem_val = s.mem_val;
    fwd_wb_we = s.wb_we; fwd_wb_reg = s.wb_reg; fwd_wb_val = s.wb_val;
  endtask

  task automatic check_model();
    beat_t h;
    chk("out_valid", DW'(out_valid), DW'(model_q.size() != 0));
    chk("in_ready", DW'(in_ready), DW'(model_q.size() < 2));
    if (model_q.size() != 0) begin
      h = model_q[0];
      chk("out_a", out_a, h.a);
      chk("out_b", out_b, h.b);
      chk("out_f", DW'(out_f), DW'(h.f));
      chk("out_shamt", DW'(out_shamt), DW'(h.shamt));
      chk("out_dst", DW'(out_dst), DW'(h.dst));
      chk("out_illegal", DW'(out_illegal), DW'(h.ill));
    end
  endtask

  // One clock: called just after a falling edge, returns after the next one
  task automatic cycle(input stim_t s);
    bit acc, cons;
    check_model();
    drive(s);
    if (out_valid && s.ready) log_a.push_back(out_a);
    acc  = s.valid && (model_q.size() < 2);
    cons = s.ready && (model_q.size() > 0);
    @(posedge clk);
    if (s.flush) model_q.delete();
    else begin
      if (cons) void'(model_q.pop_front());
      if (acc) model_q.push_back(ref_beat(s));
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[$];
    vec_t  v;
    stim_t s;

    // aluop funct shamt rs rs_val rt rt_val alusrc imm memwe memreg memval wbwe wbreg wbval | a b f ill
    vecs.push_back(mkv(2'b10, 6'h20, 5'd0, 5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b00, 6'h00, 5'd0, 5'd3, 32'd1, 5'd4, 32'd7, 1'b0, 32'd0,
                       1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 32'h10, 32'd7, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b00, 6'h00, 5'd0, 5'd3, 32'd1, 5'd4, 32'd7, 1'b0, 32'd0,
                       1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20, 32'h20, 32'd7, 4'h2, 1'b0));
    vecs.push_back(mkv(2'b11, 6'h00, 5'd0, 5'd0, 32'h55, 5'd0, 32'h66, 1'b0, 32'd0,
                       1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77, 32'h55, 32'h66, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h02, 5'd4, 5'd1, 32'd9, 5'd5, 32'h80, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd9, 32'h80, 4'he, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h3f, 5'd0, 5'd1, 32'd2, 5'd2, 32'd3, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd2, 32'd3, 4'hf, 1'b1));
    vecs.push_back(mkv(2'b01, 6'h00, 5'd0, 5'd1, 32'd2, 5'd7, 32'd3, 1'b1, 32'hfffffff0,
                       1'b1, 5'd7, 32'habc, 1'b0, 5'd0, 32'd0, 32'd2, 32'hfffffff0, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h2a, 5'd0, 5'd1, 32'd2, 5'd7, 32'd3, 1'b0, 32'd0,
                       1'b1, 5'd7, 32'habc, 1'b1, 5'd7, 32'hdef, 32'd2, 32'habc, 4'h7, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h24, 5'd0, 5'd2, 32'd4, 5'd6, 32'd8, 1'b0, 32'd0,
                       1'b0, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2, 32'd4, 32'h2, 4'h0, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h25, 5'd0, 5'd2, 32'd4, 5'd6, 32'd8, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd4, 32'd8, 4'h1, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h22, 5'd0, 5'd2, 32'd4, 5'd6, 32'd8, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd4, 32'd8, 4'h6, 1'b0));
    vecs.push_back(mkv(2'b10, 6'h00, 5'd31, 5'd2, 32'd4, 5'd6, 32'd8, 1'b0, 32'd0,
                       1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd4, 32'd8, 4'h3, 1'b0));

    // Power-on reset state
    reset_n = 1'b0;
    drive(idle(1'b0));
    repeat (2) @(negedge clk);
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_ready", DW'(in_ready), 32'd1);
    chk("rst_a", out_a, '0);
    chk("rst_f", DW'(out_f), '0);
    chk("rst_illegal", DW'(out_illegal), '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Vector table, one beat at a time
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.s.dst = RW'(i);
      cycle(v.s);
      chk($sformatf("vec%0d_valid", i), DW'(out_valid), 32'd1);
      chk($sformatf("vec%0d_a", i), out_a, v.e.a);
      chk($sformatf("vec%0d_b", i), out_b, v.e.b);
      chk($sformatf("vec%0d_f", i), DW'(out_f), DW'(v.e.f));
      chk($sformatf("vec%0d_shamt", i), DW'(out_shamt), DW'(v.e.shamt));
      chk($sformatf("vec%0d_dst", i), DW'(out_dst), DW'(i));
      chk($sformatf("vec%0d_illegal", i), DW'(out_illegal), DW'(v.e.ill));
      cycle(idle(1'b1));
    end

    // Backpressure: three beats into a two-entry buffer, then drain in order
    log_a.delete();
    cycle(simple(32'd1, 1'b0));
    cycle(simple(32'd2, 1'b0));
    chk("bp_ready_low", DW'(in_ready), '0);
    cycle(simple(32'd3, 1'b0));
    cycle(simple(32'd3, 1'b0));
    cycle(simple(32'd3, 1'b1));
    cycle(simple(32'd3, 1'b1));
    cycle(idle(1'b1));
    cycle(idle(1'b1));
    chk("bp_count", DW'(log_a.size()), 32'd3);
    if (log_a.size() == 3) begin
      chk("bp_order0", log_a[0], 32'd1);
      chk("bp_order1", log_a[1], 32'd2);
      chk("bp_order2", log_a[2], 32'd3);
    end

    // Flush while full with a beat offered, then flush in ONE with an accepted beat
    log_a.delete();
    cycle(simple(32'd11, 1'b0));
    cycle(simple(32'd12, 1'b0));
    s = simple(32'd13, 1'b0);
    s.flush = 1'b1;
    cycle(s);
    chk("flush2_valid", DW'(out_valid), '0);
    chk("flush2_ready", DW'(in_ready), 32'd1);
    cycle(simple(32'd14, 1'b0));
    s = simple(32'd15, 1'b0);
    s.flush = 1'b1;
    cycle(s);
    chk("flush1_valid", DW'(out_valid), '0);
    repeat (3) cycle(idle(1'b1));
    chk("flush_no_beat", DW'(log_a.size()), '0);

    // Asynchronous reset in the middle of traffic
    cycle(simple(32'h33, 1'b0));
    cycle(simple(32'h34, 1'b0));
    drive(idle(1'b0));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(out_valid), '0);
    chk("mid_rst_ready", DW'(in_ready), 32'd1);
    chk("mid_rst_a", out_a, '0);
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(idle(1'b1));

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      s = idle(1'b0);
      s.valid   = ($urandom_range(0, 9) < 7);
      s.ready   = ($urandom_range(0, 9) < 6);
      s.flush   = ($urandom_range(0, 19) == 0);
      s.aluop   = 2'($urandom_range(0, 3));
      s.funct   = ($urandom_range(0, 1) != 0) ? FN[$urandom_range(0, 6)] : 6'($urandom);
      s.shamt   = 5'($urandom);
      s.rs      = RW'($urandom_range(0, 7));
      s.rt      = RW'($urandom_range(0, 7));
      s.dst     = RW'($urandom);
      s.rs_val  = $urandom;
      s.rt_val  = $urandom;
      s.imm     = $urandom;
      s.alusrc  = 1'($urandom_range(0, 1));
      s.mem_we  = 1'($urandom_range(0, 1));
      s.mem_reg = RW'($urandom_range(0, 7));
      s.mem_val = $urandom;
      s.wb_we   = 1'($urandom_range(0, 1));
      s.wb_reg  = RW'($urandom_range(0, 7));
      s.wb_val  = $urandom;
      cycle(s);
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
